// File: rtl/mem_load_store_unit_if.sv
// Request/response and data-memory bus of the load/store sequencer.
// The slave side is the sequencer; the master side is the CPU datapath plus the data memory.
interface mem_load_store_unit_if;
   logic        start;
   logic        is_store;
   logic [1:0]  size;
   logic        unsigned_ld;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic [31:0] mem_rdata;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        busy;
   logic        done;
   logic        misaligned;
   logic [31:0] mem_out;
   logic [31:0] mem_ext_out;

   modport master (
      output start, is_store, size, unsigned_ld, addr, store_data, mem_rdata,
      input  mem_addr, mem_wdata, mem_we, busy, done, misaligned, mem_out, mem_ext_out
   );

   modport slave (
      input  start, is_store, size, unsigned_ld, addr, store_data, mem_rdata,
      output mem_addr, mem_wdata, mem_we, busy, done, misaligned, mem_out, mem_ext_out
   );
endinterface

// File: rtl/mem_load_store_unit.sv
// Memory-side load/store sequencer: one access per start pulse against a synchronous-read
// data memory, with sub-word extraction on loads and read-modify-write for sub-word stores.
module mem_load_store_unit #(
   parameter int MEM_LAT = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   mem_load_store_unit_if.slave   bus
);
   localparam int CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (MEM_LAT >= 2) ? CNT_W'(MEM_LAT - 2) : '0;

   typedef enum logic [2:0] {IDLE, RD_WAIT, CAPTURE, WRITE, DONE} state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             req_store_reg;
   logic [1:0]       req_size_reg;
   logic             req_unsigned_reg;
   logic [31:0]      req_addr_reg;
   logic [31:0]      req_data_reg;

   logic [31:0]      mem_addr_reg;
   logic [31:0]      mem_wdata_reg;
   logic             mem_we_reg;
   logic             busy_reg;
   logic             done_reg;
   logic             misaligned_reg;
   logic [31:0]      mem_out_reg;
   logic [31:0]      mem_ext_out_reg;

   logic             req_word;
   logic             req_misaligned;

   // size 00 and 11 both mean a full word
   assign req_word       = (bus.size == 2'b00) || (bus.size == 2'b11);
   assign req_misaligned = ((bus.size == 2'b01) && bus.addr[0]) ||
                           (req_word && (bus.addr[1:0] != 2'b00));

   function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] sz,
                                           input logic [1:0] lane, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (sz)
         2'b10:   r = {{24{b[7] & ~uns}}, b};
         2'b01:   r = {{16{h[15] & ~uns}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] data,
                                         input logic [1:0] sz, input logic [1:0] lane);
      logic [31:0] r;
      r = word;
      case (sz)
         2'b10: begin
            case (lane)
               2'd0:    r[7:0]   = data[7:0];
               2'd1:    r[15:8]  = data[7:0];
               2'd2:    r[23:16] = data[7:0];
               default: r[31:24] = data[7:0];
            endcase
         end
         2'b01: begin
            if (lane[1]) r[31:16] = data[15:0];
            else         r[15:0]  = data[15:0];
         end
         default: r = data;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= IDLE;
         cnt_reg          <= '0;
         req_store_reg    <= 1'b0;
         req_size_reg     <= 2'b00;
         req_unsigned_reg <= 1'b0;
         req_addr_reg     <= '0;
         req_data_reg     <= '0;
         mem_addr_reg     <= '0;
         mem_wdata_reg    <= '0;
         mem_we_reg       <= 1'b0;
         busy_reg         <= 1'b0;
         done_reg         <= 1'b0;
         misaligned_reg   <= 1'b0;
         mem_out_reg      <= '0;
         mem_ext_out_reg  <= '0;
      end else begin
         mem_we_reg <= 1'b0;
         done_reg   <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  req_store_reg    <= bus.is_store;
                  req_size_reg     <= bus.size;
                  req_unsigned_reg <= bus.unsigned_ld;
                  req_addr_reg     <= bus.addr;
                  req_data_reg     <= bus.store_data;
                  busy_reg         <= 1'b1;
                  misaligned_reg   <= req_misaligned;
                  if (req_misaligned) begin
                     // aborted access: memory bus left untouched
                     done_reg  <= 1'b1;
                     state_reg <= DONE;
                  end else begin
                     mem_addr_reg <= {bus.addr[31:2], 2'b00};
                     if (bus.is_store && req_word) begin
                        mem_wdata_reg <= bus.store_data;
                        mem_we_reg    <= 1'b1;
                        state_reg     <= WRITE;
                     end else begin
                        cnt_reg   <= '0;
                        state_reg <= (MEM_LAT == 1) ? CAPTURE : RD_WAIT;
                     end
                  end
               end
            end
            RD_WAIT: begin
               if (cnt_reg == CNT_LAST) state_reg <= CAPTURE;
               else                     cnt_reg   <= cnt_reg + 1'b1;
            end
            CAPTURE: begin
               if (req_store_reg) begin
                  mem_wdata_reg <= merge(bus.mem_rdata, req_data_reg, req_size_reg, req_addr_reg[1:0]);
                  mem_we_reg    <= 1'b1;
                  state_reg     <= WRITE;
               end else begin
                  mem_out_reg     <= bus.mem_rdata;
                  mem_ext_out_reg <= extract(bus.mem_rdata, req_size_reg, req_addr_reg[1:0],
                                             req_unsigned_reg);
                  done_reg        <= 1'b1;
                  state_reg       <= DONE;
               end
            end
            WRITE: begin
               done_reg  <= 1'b1;
               state_reg <= DONE;
            end
            DONE: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.mem_addr    = mem_addr_reg;
   assign bus.mem_wdata   = mem_wdata_reg;
   assign bus.mem_we      = mem_we_reg;
   assign bus.busy        = busy_reg;
   assign bus.done        = done_reg;
   assign bus.misaligned  = misaligned_reg;
   assign bus.mem_out     = mem_out_reg;
   assign bus.mem_ext_out = mem_ext_out_reg;
endmodule

// File: tb/tb_mem_load_store_unit.sv
// Randomized bench for mem_load_store_unit against an array-based memory model.
module tb_mem_load_store_unit;
   localparam int MEM_LAT = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   mem_load_store_unit_if bus();

   mem_load_store_unit #(.MEM_LAT(MEM_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // synchronous-read data memory; preload port lets the bench seed words
   logic [31:0] ram [0:63];
   logic        pre_we = 1'b0;
   logic [5:0]  pre_idx = '0;
   logic [31:0] pre_val = '0;
   always @(posedge clk) begin
      if (pre_we)          ram[pre_idx] <= pre_val;
      else if (bus.mem_we) ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr[7:2]];
   end

   logic [31:0] model_mem [0:63];
   logic [31:0] exp_out = '0;
   logic [31:0] exp_ext = '0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_word(input int idx, input logic [31:0] val);
      @(negedge clk);
      pre_we = 1'b1; pre_idx = 6'(idx); pre_val = val;
      model_mem[idx] = val;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic do_op(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d, input logic poke_done);
      logic [31:0] old, v, nw, we_data, we_addr;
      int k, exp_done, exp_we, cyc, we_cnt, we_cyc, done_cyc, extra;
      logic mis, wsz, got_done;
      wsz = (sz == 2'b00) || (sz == 2'b11);
      mis = ((sz == 2'b01) && a[0]) || (wsz && a[1:0] != 2'b00);
      k   = int'(a[1:0]);
      old = model_mem[a[7:2]];
      exp_done = mis ? 1 : (st ? (wsz ? 2 : MEM_LAT + 2) : MEM_LAT + 1);
      exp_we   = (mis || !st) ? 0 : exp_done - 1;
      nw = old;
      if (!mis && st) begin
         if (wsz)            nw = d;
         else if (sz == 2'b10) nw = (old & ~(32'hFF << (8 * k))) | ((d & 32'hFF) << (8 * k));
         else                nw = (old & ~(32'hFFFF << (16 * (k / 2)))) |
                                  ((d & 32'hFFFF) << (16 * (k / 2)));
      end
      if (!mis && !st) begin
         if (sz == 2'b10) begin
            v = (old >> (8 * k)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
         end else if (sz == 2'b01) begin
            v = (old >> (16 * (k / 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
         end else v = old;
         exp_out = old;
         exp_ext = v;
      end

      @(negedge clk);
      bus.start = 1'b1; bus.is_store = st; bus.size = sz; bus.unsigned_ld = uns;
      bus.addr = a; bus.store_data = d;
      @(negedge clk);
      bus.start = 1'b0; bus.is_store = 1'($urandom); bus.size = 2'($urandom);
      bus.unsigned_ld = 1'($urandom); bus.addr = $urandom; bus.store_data = $urandom;
      cyc = 1; we_cnt = 0; we_cyc = 0; done_cyc = 0; got_done = 1'b0;
      we_data = '0; we_addr = '0;
      check_val("busy_c1", 32'(bus.busy), 32'd1);
      while (!got_done && cyc <= 16) begin
         if (bus.mem_we) begin
            we_cnt++; we_cyc = cyc; we_data = bus.mem_wdata; we_addr = bus.mem_addr;
         end
         if (bus.done) begin
            got_done = 1'b1; done_cyc = cyc;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      check_val("done_seen", 32'(got_done), 32'd1);
      check_val("done_cycle", 32'(done_cyc), 32'(exp_done));
      check_val("busy_done", 32'(bus.busy), 32'd1);
      check_val("misaligned", 32'(bus.misaligned), 32'(mis));
      check_val("we_count", 32'(we_cnt), (exp_we != 0) ? 32'd1 : 32'd0);
      if (exp_we != 0) begin
         check_val("we_cycle", 32'(we_cyc), 32'(exp_we));
         check_val("we_addr", we_addr, {a[31:2], 2'b00});
         check_val("we_data", we_data, nw);
      end
      check_val("mem_out", bus.mem_out, exp_out);
      check_val("mem_ext_out", bus.mem_ext_out, exp_ext);
      if (poke_done) begin
         bus.start = 1'b1; bus.is_store = 1'b1; bus.size = 2'b00; bus.addr = {a[31:2], 2'b00};
      end
      @(negedge clk);
      bus.start = 1'b0;
      check_val("busy_after", 32'(bus.busy), 32'd0);
      extra = 0;
      for (int i = 0; i < 3; i++) begin
         if (bus.done || bus.mem_we || bus.busy) extra++;
         @(negedge clk);
      end
      check_val("quiet_after", 32'(extra), 32'd0);
      model_mem[a[7:2]] = nw;
      check_val("ram_word", ram[a[7:2]], nw);
      $display("op %s size=%0d uns=%0b addr=%h data=%h -> done@%0d mis=%0b ext=%h",
               st ? "store" : "load ", sz, uns, a, d, done_cyc, bus.misaligned, bus.mem_ext_out);
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      bus.start = 1'b0; bus.is_store = 1'b0; bus.size = 2'b00; bus.unsigned_ld = 1'b0;
      bus.addr = '0; bus.store_data = '0;
      repeat (3) @(negedge clk);
      check_val("rst_busy", 32'(bus.busy), 32'd0);
      check_val("rst_done", 32'(bus.done), 32'd0);
      check_val("rst_we", 32'(bus.mem_we), 32'd0);
      check_val("rst_addr", bus.mem_addr, 32'd0);
      check_val("rst_mem_out", bus.mem_out, 32'd0);
      check_val("rst_ext", bus.mem_ext_out, 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 64; i++) set_word(i, $urandom);

      set_word(32'h10 >> 2, 32'h8899AABB);
      do_op(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0);
      do_op(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b0);
      check_val("lb_signed", bus.mem_ext_out, 32'hFFFFFF88);
      do_op(1'b0, 2'b10, 1'b1, 32'h13, 32'h0, 1'b1);
      check_val("lb_unsigned", bus.mem_ext_out, 32'h00000088);
      set_word(32'h20 >> 2, 32'hDEADBEEF);
      do_op(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234, 1'b0);
      check_val("sh_word", ram[32'h20 >> 2], 32'h1234BEEF);
      do_op(1'b1, 2'b00, 1'b0, 32'h40, 32'hCAFEF00D, 1'b0);
      do_op(1'b0, 2'b01, 1'b0, 32'h05, 32'h0, 1'b0);

      for (int n = 0; n < 250; n++) begin
         sz = 2'($urandom);
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'b01) a[0] = 1'b0;
            else if (sz != 2'b10) a[1:0] = 2'b00;
         end
         do_op(1'($urandom), sz, 1'($urandom), a, $urandom, ($urandom_range(0, 7) == 0));
      end

      // reset while the load sits in RD_WAIT
      @(negedge clk);
      bus.start = 1'b1; bus.is_store = 1'b0; bus.size = 2'b00; bus.addr = 32'h10;
      @(negedge clk);
      bus.start = 1'b0;
      reset = 1'b1;
      #1;
      check_val("mid_rst_busy", 32'(bus.busy), 32'd0);
      check_val("mid_rst_we", 32'(bus.mem_we), 32'd0);
      check_val("mid_rst_addr", bus.mem_addr, 32'd0);
      check_val("mid_rst_out", bus.mem_out, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      begin
         int seen = 0;
         for (int i = 0; i < 6; i++) begin
            if (bus.done || bus.busy) seen++;
            @(negedge clk);
         end
         check_val("mid_rst_no_done", 32'(seen), 32'd0);
      end
      exp_out = '0;
      exp_ext = '0;
      do_op(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
